// File: rtl/hynoc_ingress_v2.sv
// hynoc_ingress_v2: router ingress port -- input flit FIFO, header decode/rewrite and egress forwarding FSM.
// Statistics counters are built only when HYNOC_INGRESS_STATS_EN is defined; otherwise stat_* read 0.
module hynoc_ingress_v2 #(
  parameter int NB_PORTS        = 5,
  parameter int INDEX_WIDTH     = 4,
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int MAX_PKT_FLITS   = 64,
  localparam int FLIT_WIDTH     = PAYLOAD_WIDTH + 1,
  localparam int NE             = NB_PORTS - 1
) (
  input  logic                     router_clk,
  input  logic                     router_srst,
  input  logic                     wen,
  input  logic [FLIT_WIDTH-1:0]    wdata,
  output logic                     wfull,
  output logic [LOG2_FIFO_DEPTH:0] wlevel,
  input  logic [NE-1:0]            from_egress_grant,
  input  logic [NE-1:0]            from_egress_afull,
  output logic [NE-1:0]            to_egress_request,
  output logic                     to_egress_write,
  output logic [FLIT_WIDTH-1:0]    to_egress_data,
  output logic [15:0]              stat_pkt,
  output logic [15:0]              stat_drop,
  output logic [15:0]              stat_trunc
);

  localparam int DEPTH = 2 ** LOG2_FIFO_DEPTH;
  localparam int PSW   = (NE > 1) ? $clog2(NE) : 1;
  localparam int RW    = PAYLOAD_WIDTH - 4 - INDEX_WIDTH;
  localparam logic [3:0] PROTO_UNI = 4'd1;
  localparam logic [3:0] PROTO_MC  = 4'd2;
  localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE  = 1;
  localparam logic [LOG2_FIFO_DEPTH:0]   LVL_ONE  = 1;
  localparam logic [LOG2_FIFO_DEPTH:0]   LVL_FULL = {1'b1, {LOG2_FIFO_DEPTH{1'b0}}};
  localparam logic [INDEX_WIDTH-1:0]     IDX_ONE  = 1;
  localparam logic [15:0]                CNT_ONE  = 16'd1;
  localparam logic [15:0]                CNT_MAX  = 16'(MAX_PKT_FLITS);

  // IDLE: decode FIFO head | ROUTE: wait for grants | FWD: forward packet | DROP: discard up to last flit
  typedef enum logic [1:0] {IDLE, ROUTE, FWD, DROP} state_t;

  logic [FLIT_WIDTH-1:0]      mem_q [DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG2_FIFO_DEPTH:0]   level_q, level_d;
  logic                       push, pop, empty;
  logic [FLIT_WIDTH-1:0]      head;

  state_t                     state_q, state_d;
  logic [NE-1:0]              req_q, req_d;
  logic                       wr_q, wr_d;
  logic [FLIT_WIDTH-1:0]      data_q, data_d;
  logic [15:0]                cnt_q, cnt_d;
  logic                       hdr_q, hdr_d;
  logic                       ev_pkt, ev_drop, ev_trunc;

  logic [3:0]                 proto;
  logic [PSW-1:0]             port;
  logic [INDEX_WIDTH-1:0]     index;
  logic [RW-1:0]              rfield, rfield_out;
  logic [NE-1:0]              uni_mask, mc_mask, dec_mask;
  logic                       dec_valid;
  logic [FLIT_WIDTH-1:0]      hdr_fwd;

  assign empty  = (level_q == '0);
  assign wfull  = (level_q == LVL_FULL);
  assign wlevel = level_q;
  assign push   = wen && !wfull;
  assign head   = mem_q[rd_ptr_q];

  assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge router_clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // The header stays at the FIFO head until FWD pops it, so decode always reads the head.
  assign proto   = head[PAYLOAD_WIDTH-1 -: 4];
  assign port    = head[INDEX_WIDTH +: PSW];
  assign index   = head[INDEX_WIDTH-1:0];
  assign mc_mask = head[INDEX_WIDTH +: NE];
  assign rfield  = head[INDEX_WIDTH +: RW];

  always_comb begin
    uni_mask  = '0;
    dec_mask  = '0;
    dec_valid = 1'b0;
    for (int i = 0; i < NE; i++) uni_mask[i] = (int'(port) == i);
    if (proto == PROTO_UNI && int'(port) < NE) begin
      dec_valid = 1'b1;
      dec_mask  = uni_mask;
    end else if (proto == PROTO_MC && mc_mask != '0) begin
      dec_valid = 1'b1;
      dec_mask  = mc_mask;
    end
  end

  always_comb begin
    rfield_out = rfield;
    if (proto == PROTO_UNI) rfield_out = rfield >> PSW;
  end

  assign hdr_fwd = {1'b0, proto, rfield_out, index - IDX_ONE};

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wr_d     = 1'b0;
    data_d   = data_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    pop      = 1'b0;
    ev_pkt   = 1'b0;
    ev_drop  = 1'b0;
    ev_trunc = 1'b0;
    case (state_q)
      IDLE: begin
        req_d = '0;
        cnt_d = '0;
        if (!empty) begin
          if (dec_valid && !head[PAYLOAD_WIDTH]) begin
            state_d = ROUTE;
            req_d   = dec_mask;
          end else begin
            state_d = DROP;
            ev_drop = 1'b1;
          end
        end
      end
      ROUTE: begin
        if ((from_egress_grant & req_q) == req_q) begin
          state_d = FWD;
          hdr_d   = 1'b1;
          ev_pkt  = 1'b1;
        end
      end
      FWD: begin
        if (!empty && (from_egress_afull & req_q) == '0) begin
          pop = 1'b1;
          if (hdr_q) begin
            hdr_d = 1'b0;
            if (index != '0) begin
              wr_d   = 1'b1;
              data_d = hdr_fwd;
              cnt_d  = cnt_q + CNT_ONE;
            end
          end else begin
            wr_d   = 1'b1;
            data_d = head;
            cnt_d  = cnt_q + CNT_ONE;
            if (head[PAYLOAD_WIDTH]) begin
              state_d = IDLE;
            end else if (cnt_d == CNT_MAX) begin
              data_d[PAYLOAD_WIDTH] = 1'b1;
              state_d  = DROP;
              ev_trunc = 1'b1;
            end
          end
        end
      end
      DROP: begin
        req_d = '0;
        if (!empty) begin
          pop = 1'b1;
          if (head[PAYLOAD_WIDTH]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge router_clk or negedge router_srst) begin
    if (!router_srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= IDLE;
      req_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      hdr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
    end
  end

  assign to_egress_request = req_q;
  assign to_egress_write   = wr_q;
  assign to_egress_data    = data_q;

`ifdef HYNOC_INGRESS_STATS_EN
  logic [15:0] stat_pkt_q, stat_pkt_d, stat_drop_q, stat_drop_d, stat_trunc_q, stat_trunc_d;

  always_comb begin
    stat_pkt_d   = stat_pkt_q;
    stat_drop_d  = stat_drop_q;
    stat_trunc_d = stat_trunc_q;
    if (ev_pkt   && stat_pkt_q   != 16'hFFFF) stat_pkt_d   = stat_pkt_q   + CNT_ONE;
    if (ev_drop  && stat_drop_q  != 16'hFFFF) stat_drop_d  = stat_drop_q  + CNT_ONE;
    if (ev_trunc && stat_trunc_q != 16'hFFFF) stat_trunc_d = stat_trunc_q + CNT_ONE;
  end

  always_ff @(posedge router_clk or negedge router_srst) begin
    if (!router_srst) begin
      stat_pkt_q   <= '0;
      stat_drop_q  <= '0;
      stat_trunc_q <= '0;
    end else begin
      stat_pkt_q   <= stat_pkt_d;
      stat_drop_q  <= stat_drop_d;
      stat_trunc_q <= stat_trunc_d;
    end
  end

  assign stat_pkt   = stat_pkt_q;
  assign stat_drop  = stat_drop_q;
  assign stat_trunc = stat_trunc_q;
`else
  logic unused_ev;
  assign unused_ev  = ev_pkt ^ ev_drop ^ ev_trunc;
  assign stat_pkt   = '0;
  assign stat_drop  = '0;
  assign stat_trunc = '0;
`endif

endmodule

// File: tb/tb_hynoc_ingress_v2.sv
// tb_hynoc_ingress_v2: directed bench for hynoc_ingress_v2 (default instance plus a MAX_PKT_FLITS=8 instance).
// Statistics expectations follow whether HYNOC_INGRESS_STATS_EN is defined for the build.
module tb_hynoc_ingress_v2;

`ifdef HYNOC_INGRESS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        wen = 1'b0;
  logic [32:0] wdata = '0;
  logic        sel = 1'b0;
  logic [3:0]  grant = 4'b1111;
  logic [3:0]  afull = 4'b0000;
  logic        wen_a, wen_b;

  logic        wfull_a, wfull_b, wr_a, wr_b;
  logic [5:0]  wlevel_a, wlevel_b;
  logic [3:0]  req_a, req_b;
  logic [32:0] data_a, data_b;
  logic [15:0] sp_a, sd_a, st_a, sp_b, sd_b, st_b;

  logic        out_wr;
  logic [3:0]  out_req;
  logic [32:0] out_data;

  assign wen_a    = wen & ~sel;
  assign wen_b    = wen & sel;
  assign out_wr   = sel ? wr_b : wr_a;
  assign out_req  = sel ? req_b : req_a;
  assign out_data = sel ? data_b : data_a;

  hynoc_ingress_v2 u_dut (
    .router_clk(clk), .router_srst(rst_b), .wen(wen_a), .wdata(wdata),
    .wfull(wfull_a), .wlevel(wlevel_a),
    .from_egress_grant(grant), .from_egress_afull(afull),
    .to_egress_request(req_a), .to_egress_write(wr_a), .to_egress_data(data_a),
    .stat_pkt(sp_a), .stat_drop(sd_a), .stat_trunc(st_a)
  );

  hynoc_ingress_v2 #(.MAX_PKT_FLITS(8)) u_trunc (
    .router_clk(clk), .router_srst(rst_b), .wen(wen_b), .wdata(wdata),
    .wfull(wfull_b), .wlevel(wlevel_b),
    .from_egress_grant(grant), .from_egress_afull(afull),
    .to_egress_request(req_b), .to_egress_write(wr_b), .to_egress_data(data_b),
    .stat_pkt(sp_b), .stat_drop(sd_b), .stat_trunc(st_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] hdr(input logic [3:0] proto, input logic [23:0] route,
                                      input logic [3:0] idx);
    return {1'b0, proto, route, idx};
  endfunction

  // Output monitor: records every forwarded flit with the request and cycle it was seen in.
  logic [32:0] obs_q[$];
  logic [3:0]  obs_req_q[$];
  int          obs_t_q[$];
  logic [32:0] exp_q[$];
  int          cyc = 0;
  logic [3:0]  afull_prev = '0;
  int          afull_viol = 0;
  bit          follow_pending = 1'b0;
  logic [3:0]  last_follow_req = '1;
  bit          rand_afull = 1'b0;

  always @(posedge clk) begin
    cyc++;
    afull_prev = afull;
  end

  always @(negedge clk) begin
    if (follow_pending) begin
      last_follow_req = out_req;
      follow_pending  = 1'b0;
    end
    if (out_wr) begin
      obs_q.push_back(out_data);
      obs_req_q.push_back(out_req);
      obs_t_q.push_back(cyc);
      if (afull_prev != '0) afull_viol++;
      if (out_data[32]) follow_pending = 1'b1;
    end
    if (rand_afull) afull = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0000;
  end

  task automatic send(input logic [32:0] f);
    @(negedge clk);
    wen   = 1'b1;
    wdata = f;
  endtask

  task automatic send_end();
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic clr();
    obs_q.delete();
    obs_req_q.delete();
    obs_t_q.delete();
    exp_q.delete();
    last_follow_req = '1;
  endtask

  task automatic expect_out(input string tag, input int budget);
    int k = 0;
    while (obs_q.size() < exp_q.size() && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, obs_q.size() >= exp_q.size(), 1);
    repeat (6) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_flit%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_hdr;
    int k;
    logic [32:0] f;

    // Reset state
    #1;
    chk("rst_wr", wr_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_req", req_a, 0);
    chk("rst_wlevel", wlevel_a, 0);
    chk("rst_wfull", wfull_a, 0);
    chk("rst_stat_pkt", sp_a, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Proto-0 last-flagged flit dropped, then unicast port 3 index 1 with 40 payload flits
    clr();
    send({1'b1, 32'h0123_4567});
    send_end();
    repeat (4) @(negedge clk);
    send(hdr(4'h1, 24'h0000B7, 4'h1));
    t_hdr = cyc;
    exp_q.push_back(hdr(4'h1, 24'h00002D, 4'h0));
    for (int i = 0; i < 40; i++) begin
      f = {(i == 39), 32'hA000_0000 + 32'(i)};
      send(f);
      exp_q.push_back(f);
    end
    send_end();
    expect_out("t1", 200);
    if (obs_t_q.size() > 0) begin
      chk("t1_latency", obs_t_q[0] - t_hdr, 4);
      chk("t1_req", obs_req_q[0], 4'b1000);
    end
    chk("t1_req_after_last", last_follow_req, 4'b0000);
    chk("t1_stat_drop", sd_a, STATS ? 16'd1 : 16'd0);
    chk("t1_stat_pkt", sp_a, STATS ? 16'd1 : 16'd0);

    // Unicast index 0: header consumed, single last payload forwarded
    clr();
    send(hdr(4'h1, 24'h000001, 4'h0));
    send({1'b1, 32'hCAFE_DECA});
    send_end();
    exp_q.push_back({1'b1, 32'hCAFE_DECA});
    expect_out("t2", 50);
    if (obs_req_q.size() > 0) chk("t2_req", obs_req_q[0], 4'b0010);

    // Multicast 0111, index 1; partial grant must hold the packet in ROUTE
    clr();
    grant = 4'b0011;
    send(hdr(4'h2, 24'h000007, 4'h1));
    exp_q.push_back(hdr(4'h2, 24'h000007, 4'h0));
    for (int i = 0; i < 10; i++) begin
      f = {(i == 9), 32'(9 - i)};
      send(f);
      exp_q.push_back(f);
    end
    send_end();
    repeat (8) @(negedge clk);
    chk("t3_no_fwd_partial_grant", obs_q.size(), 0);
    chk("t3_req_in_route", req_a, 4'b0111);
    grant = 4'b1111;
    expect_out("t3", 100);
    if (obs_req_q.size() == 11) begin
      chk("t3_req_first", obs_req_q[0], 4'b0111);
      chk("t3_req_last", obs_req_q[10], 4'b0111);
    end
    chk("t3_req_after_last", last_follow_req, 4'b0000);

    // Truncation on the MAX_PKT_FLITS=8 instance, followed by a normal packet
    clr();
    sel = 1'b1;
    send(hdr(4'h1, 24'h00000E, 4'h1));
    exp_q.push_back(hdr(4'h1, 24'h000003, 4'h0));
    for (int i = 0; i < 19; i++) begin
      f = {(i == 18), 32'h5000_0000 + 32'(i)};
      send(f);
      if (i < 6) exp_q.push_back(f);
      if (i == 6) exp_q.push_back({1'b1, f[31:0]});
    end
    send(hdr(4'h1, 24'h000001, 4'h1));
    exp_q.push_back(hdr(4'h1, 24'h000000, 4'h0));
    for (int i = 0; i < 3; i++) begin
      f = {(i == 2), 32'h6000_0000 + 32'(i)};
      send(f);
      exp_q.push_back(f);
    end
    send_end();
    expect_out("t4", 200);
    if (obs_req_q.size() == 12) begin
      chk("t4_req_trunc", obs_req_q[0], 4'b0100);
      chk("t4_req_next", obs_req_q[8], 4'b0010);
    end
    chk("t4_stat_trunc", st_b, STATS ? 16'd1 : 16'd0);
    chk("t4_stat_pkt", sp_b, STATS ? 16'd2 : 16'd0);
    chk("t4_stat_drop", sd_b, 0);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // Fill to 32 with afull set and wen held; then drain with random afull
    clr();
    afull = 4'b1111;
    afull_viol = 0;
    send(hdr(4'h1, 24'h000AB0, 4'h2));
    exp_q.push_back(hdr(4'h1, 24'h0002AC, 4'h1));
    for (int i = 0; i < 31; i++) begin
      f = {(i == 30), 32'h7000_0000 + 32'(i)};
      send(f);
      exp_q.push_back(f);
      if (i == 30) begin
        chk("t5_level31", wlevel_a, 31);
        chk("t5_not_full", wfull_a, 0);
      end
    end
    for (int j = 0; j < 5; j++) send({1'b1, 32'hDEAD_0000 + 32'(j)});
    send_end();
    chk("t5_full", wfull_a, 1);
    chk("t5_level32", wlevel_a, 32);
    rand_afull = 1'b1;
    expect_out("t5", 400);
    rand_afull = 1'b0;
    afull = 4'b0000;
    chk("t5_afull_rule", afull_viol, 0);
    chk("t5_empty", wlevel_a, 0);

    // Reset mid-FWD, then a fresh packet
    clr();
    afull = 4'b1111;
    send(hdr(4'h2, 24'h000009, 4'h3));
    for (int i = 0; i < 20; i++) send({(i == 19), 32'h8000_0000 + 32'(i)});
    send_end();
    afull = 4'b0000;
    k = 0;
    while (obs_q.size() < 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_mid_fwd", obs_q.size() >= 5, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("t6_rst_wr", wr_a, 0);
    chk("t6_rst_data", data_a, 0);
    chk("t6_rst_req", req_a, 0);
    chk("t6_rst_wlevel", wlevel_a, 0);
    chk("t6_rst_stat", sp_a, 0);
    @(negedge clk);
    rst_b = 1'b1;
    follow_pending = 1'b0;
    clr();
    send(hdr(4'h1, 24'h000003, 4'h1));
    exp_q.push_back(hdr(4'h1, 24'h000000, 4'h0));
    for (int i = 0; i < 4; i++) begin
      f = {(i == 3), 32'h9000_0000 + 32'(i)};
      send(f);
      exp_q.push_back(f);
    end
    send_end();
    expect_out("t6", 100);
    if (obs_req_q.size() > 0) chk("t6_req", obs_req_q[0], 4'b1000);
    chk("t6_stat_pkt", sp_a, STATS ? 16'd1 : 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hynoc_ingress_v2.md
HYNOC_INGRESS_V2 -- requirements
Module: hynoc_ingress_v2

Interface
REQ-001 SHALL have parameter NB_PORTS, default 5: router port count; egress targets = NB_PORTS-1.
REQ-002 SHALL have parameter INDEX_WIDTH, default 4: width of the header hop-index field, header[INDEX_WIDTH-1:0].
REQ-003 SHALL have parameter LOG2_FIFO_DEPTH, default 5: input FIFO depth = 2**LOG2_FIFO_DEPTH flits.
REQ-004 SHALL have parameter PAYLOAD_WIDTH, default 32; FLIT_WIDTH = PAYLOAD_WIDTH+1, bit PAYLOAD_WIDTH = last-flit flag.
REQ-005 SHALL have parameter MAX_PKT_FLITS, default 64: maximum forwarded flits per packet, header included; legal range 2..65535.
REQ-006 router_clk  in  1  clock, all logic single domain.
REQ-007 router_srst  in  1  reset, asynchronous, active-low.
REQ-008 wen  in  1  write strobe; ignored while wfull=1.
REQ-009 wdata  in  FLIT_WIDTH  flit to store.
REQ-010 wfull  out  1  FIFO full.
REQ-011 wlevel  out  LOG2_FIFO_DEPTH+1  FIFO occupancy.
REQ-012 from_egress_grant  in  NB_PORTS-1  per-egress grant.
REQ-013 from_egress_afull  in  NB_PORTS-1  per-egress almost-full; stalls forwarding when any requested bit is set.
REQ-014 to_egress_request  out  NB_PORTS-1  egress request mask.
REQ-015 to_egress_write  out  1  flit valid on to_egress_data.
REQ-016 to_egress_data  out  FLIT_WIDTH  forwarded flit.
REQ-017 stat_pkt, stat_drop, stat_trunc  out  16 each  statistics counters (REQ-033).

Function
REQ-018 Header: proto = header[PAYLOAD_WIDTH-1:PAYLOAD_WIDTH-4]; 1 = unicast, 2 = multicast; other values = invalid.
REQ-019 Unicast: PSW = clog2(NB_PORTS-1); target port p = header[INDEX_WIDTH +: PSW]; request = one-hot bit p; p >= NB_PORTS-1 = invalid.
REQ-020 Multicast: request = header[INDEX_WIDTH +: NB_PORTS-1]; all-zero mask = invalid.
REQ-021 FSM states IDLE, ROUTE, FWD, DROP; IDLE waits for non-empty FIFO and decodes the head flit as header.
REQ-022 IDLE->DROP: invalid header or header with last flag set; DROP pops one flit per cycle, discarding, and returns to IDLE after popping a last-flagged flit (same cycle if the header itself was last).
REQ-023 IDLE->ROUTE: valid header; to_egress_request asserts the next cycle and holds constant until packet end.
REQ-024 ROUTE->FWD when (from_egress_grant & request) == request.
REQ-025 Header forwarding: index != 0 -> header popped and forwarded with index decremented by 1 and, for unicast, routing field bits [PAYLOAD_WIDTH-5:INDEX_WIDTH] shifted right by PSW (zero fill); index == 0 -> header popped and not forwarded.
REQ-026 FWD pops one flit per cycle when FIFO non-empty and (from_egress_afull & request) == 0; to_egress_write/data registered, 1 cycle after pop.
REQ-027 Forwarded-flit counter includes the forwarded header; when the counter reaches MAX_PKT_FLITS on a non-last flit, that flit is emitted with last flag forced to 1, state -> DROP to discard the input remainder.
REQ-028 Last-flagged flit emitted -> to_egress_request deasserts the cycle after to_egress_write, state -> IDLE; next header may be decoded that same cycle.
REQ-029 FIFO: write and pop in the same cycle keep wlevel unchanged; write when full is ignored; pop only when non-empty; pointers wrap modulo depth.
REQ-030 Latency: header written into an empty FIFO, grant returned at once -> first forwarded flit on to_egress_data 4 cycles after the wen cycle.

Reset
REQ-031 On router_srst=0, asynchronously: FIFO empty, wlevel=0, wfull=0, state IDLE, to_egress_request=0, to_egress_write=0, to_egress_data=0, flit counter 0, statistics 0.
REQ-032 Reset asserted mid-packet abandons the packet; after release, the next FIFO head flit is treated as a header.

Configuration
REQ-033 Macro HYNOC_INGRESS_STATS_EN defined: stat_pkt +1 per packet entering FWD, stat_drop +1 per IDLE->DROP, stat_trunc +1 per truncation, all saturating at 16'hFFFF; undefined: counters not built, stat_* tied to 0.

Verification
REQ-034 Proto 0 header 0x0123_4567 with last=1, then proto 1 header, index 1, port 3, 40 payload flits -> first packet discarded, request=4'b1000, header out with index 0, 40 flits out in order, stat_drop=1.
REQ-035 Unicast header index 0, port 1, one last flit 0xCAFE_DECA -> request=4'b0010, only 0xCAFE_DECA forwarded with last=1.
REQ-036 Multicast mask 4'b0111, index 1, 10 payload flits, last flit 0 -> request=4'b0111 held until last write, header forwarded with index 0, 11 flits out.
REQ-037 MAX_PKT_FLITS=8, unicast packet of 20 flits, index 1 -> 8 flits out, 8th last=1, 12 discarded, stat_trunc=1, next packet routed normally.
REQ-038 afull toggled randomly and FIFO filled to 32 with wen held -> wfull=1, no write accepted while full, no flit lost or duplicated, to_egress_write never high while afull was set on the previous cycle.
REQ-039 router_srst pulsed low mid-FWD -> all outputs 0 immediately; following packet forwarded correctly.
